// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle control sequencer sitting between register-file
// read and a 32-bit ALU. One MIPS instruction at a time is latched, decoded to
// ALU control, executed for one cycle, and reported with a single-cycle Done.
//
// Flow: IDLE -> DECODE -> EXECUTE -> WB -> IDLE (legal ops, 3 cycles to Done)
//       IDLE -> DECODE -> WB -> IDLE            (illegal ops, 2 cycles to Done)
//
// The ALU-facing outputs are registered and only ever updated on the
// DECODE->EXECUTE edge, so the ALU sees a single clean operand/control change
// per legal instruction.
module alu_op_sequencer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Funct,
    input  logic [31:0] Rs_data,
    input  logic [31:0] Rt_data,
    input  logic [15:0] Imm,
    output logic [31:0] ALU_A,
    output logic [31:0] ALU_B,
    output logic        A_invert,
    output logic        B_negate,
    output logic [1:0]  Operation,
    input  logic [31:0] ALU_Result,
    input  logic        ALU_Zero,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Result,
    output logic        Branch_Taken,
    output logic        Illegal
);

    // Opcodes
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnNor = 6'h27;
    localparam logic [5:0] FnSlt = 6'h2A;

    // ALU control words {A_invert, B_negate, Operation}
    localparam logic [3:0] CtlAnd = 4'b0000;
    localparam logic [3:0] CtlOr  = 4'b0001;
    localparam logic [3:0] CtlAdd = 4'b0010;
    localparam logic [3:0] CtlSub = 4'b0110;
    localparam logic [3:0] CtlSlt = 4'b0111;
    localparam logic [3:0] CtlNor = 4'b1100;

    typedef enum logic [1:0] {
        StIdle,
        StDecode,
        StExecute,
        StWb
    } state_e;

    state_e      state_q, state_d;

    // Instruction fields latched when a request is accepted
    logic [5:0]  opcode_q, opcode_d;
    logic [5:0]  funct_q, funct_d;
    logic [31:0] rs_q, rs_d;
    logic [31:0] rt_q, rt_d;
    logic [15:0] imm_q, imm_d;

    // ALU-facing registers
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  ctrl_q, ctrl_d;

    // Completion status registers
    logic [31:0] result_q, result_d;
    logic        branch_q, branch_d;
    logic        illegal_q, illegal_d;

    // Decoder outputs (pure function of the latched instruction)
    logic        dec_legal;
    logic [3:0]  dec_ctrl;
    logic [31:0] dec_b;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    // Decode the latched instruction into ALU control and the B operand source.
    always_comb begin
        imm_sext  = {{16{imm_q[15]}}, imm_q};
        imm_zext  = {16'h0000, imm_q};
        dec_legal = 1'b1;
        dec_ctrl  = CtlAdd;
        dec_b     = rt_q;
        unique case (opcode_q)
            OpRtype: begin
                dec_b = rt_q;
                unique case (funct_q)
                    FnAdd:   dec_ctrl = CtlAdd;
                    FnSub:   dec_ctrl = CtlSub;
                    FnAnd:   dec_ctrl = CtlAnd;
                    FnOr:    dec_ctrl = CtlOr;
                    FnNor:   dec_ctrl = CtlNor;
                    FnSlt:   dec_ctrl = CtlSlt;
                    default: dec_legal = 1'b0;
                endcase
            end
            OpAddi: begin
                dec_ctrl = CtlAdd;
                dec_b    = imm_sext;
            end
            OpSlti: begin
                dec_ctrl = CtlSlt;
                dec_b    = imm_sext;
            end
            OpAndi: begin
                dec_ctrl = CtlAnd;
                dec_b    = imm_zext;
            end
            OpOri: begin
                dec_ctrl = CtlOr;
                dec_b    = imm_zext;
            end
            // Loads and stores only use the ALU for address generation
            OpLw, OpSw: begin
                dec_ctrl = CtlAdd;
                dec_b    = imm_sext;
            end
            OpBeq, OpBne: begin
                dec_ctrl = CtlSub;
                dec_b    = rt_q;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Next-state and register-update logic for the sequencer.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        funct_d   = funct_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        imm_d     = imm_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        ctrl_d    = ctrl_q;
        result_d  = result_q;
        branch_d  = branch_q;
        illegal_d = illegal_q;

        unique case (state_q)
            StIdle: begin
                // Inputs are only sampled here; Start elsewhere is ignored.
                if (Start) begin
                    opcode_d = Opcode;
                    funct_d  = Funct;
                    rs_d     = Rs_data;
                    rt_d     = Rt_data;
                    imm_d    = Imm;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                if (dec_legal) begin
                    alu_a_d = rs_q;
                    alu_b_d = dec_b;
                    ctrl_d  = dec_ctrl;
                    state_d = StExecute;
                end else begin
                    // ALU outputs deliberately left untouched for illegal ops
                    result_d  = 32'h0;
                    branch_d  = 1'b0;
                    illegal_d = 1'b1;
                    state_d   = StWb;
                end
            end
            StExecute: begin
                result_d  = ALU_Result;
                illegal_d = 1'b0;
                if (opcode_q == OpBeq) begin
                    branch_d = ALU_Zero;
                end else if (opcode_q == OpBne) begin
                    branch_d = ~ALU_Zero;
                end else begin
                    branch_d = 1'b0;
                end
                state_d = StWb;
            end
            StWb: begin
                // Status flags are only meaningful alongside Done
                branch_d  = 1'b0;
                illegal_d = 1'b0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched instruction fields.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            opcode_q <= 6'h00;
            funct_q  <= 6'h00;
            rs_q     <= 32'h0;
            rt_q     <= 32'h0;
            imm_q    <= 16'h0;
        end else begin
            opcode_q <= opcode_d;
            funct_q  <= funct_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            imm_q    <= imm_d;
        end
    end

    // ALU operand and control registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            alu_a_q <= 32'h0;
            alu_b_q <= 32'h0;
            ctrl_q  <= 4'h0;
        end else begin
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Completion status registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            result_q  <= 32'h0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            result_q  <= result_d;
            branch_q  <= branch_d;
            illegal_q <= illegal_d;
        end
    end

    // Drive outputs straight from registered state.
    always_comb begin
        ALU_A        = alu_a_q;
        ALU_B        = alu_b_q;
        A_invert     = ctrl_q[3];
        B_negate     = ctrl_q[2];
        Operation    = ctrl_q[1:0];
        Busy         = (state_q != StIdle);
        Done         = (state_q == StWb);
        Result       = result_q;
        Branch_Taken = branch_q;
        Illegal      = illegal_q;
    end

endmodule
